// File: rtl/tictac_pkg.sv
// Shared types and constants for the tic-tac-toe player front end.
// Tile k (1..9) lives at bit 9-k of the occupancy vectors.
package tictac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic PLAYER_X = 1'b1;
    localparam logic PLAYER_O = 1'b0;

    localparam logic [2:0] ST_RUN  = 3'd0;
    localparam logic [2:0] ST_XWIN = 3'd1;
    localparam logic [2:0] ST_OWIN = 3'd2;
    localparam logic [2:0] ST_DRAW = 3'd3;
    localparam logic [2:0] ST_BAD  = 3'd4;

    // Rows, columns, then both diagonals.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'b111_000_000, 9'b000_111_000, 9'b000_000_111,
        9'b100_100_100, 9'b010_010_010, 9'b001_001_001,
        9'b100_010_001, 9'b001_010_100
    };

    function automatic logic [3:0] tile_to_bit(input logic [3:0] tile);
        return 4'd9 - tile;
    endfunction

endpackage

// File: rtl/auto_move_picker.sv
// Combinational move chooser for the automatic O player: win, then block,
// then centre, then lowest free tile. Ties go to the lowest-numbered tile.
module auto_move_picker
    import tictac_pkg::*;
(
    input  logic [8:0] own_i,
    input  logic [8:0] opp_i,
    output logic [3:0] tile_o,
    output logic       valid_o
);

    logic [8:0] free;
    logic [8:0] win_set;
    logic [8:0] blk_set;

    function automatic logic [3:0] lowest_tile(input logic [8:0] v);
        lowest_tile = 4'd0;
        for (int b = 0; b < 9; b++) begin
            if (v[b]) lowest_tile = 4'(9 - b);
        end
    endfunction

    always_comb begin
        free    = ~(own_i | opp_i);
        win_set = '0;
        blk_set = '0;
        // A free tile completes a line when the line's other two tiles are held.
        for (int b = 0; b < 9; b++) begin
            for (int l = 0; l < 8; l++) begin
                if (free[b] && WIN_LINES[l][b]) begin
                    if ((own_i & WIN_LINES[l]) == (WIN_LINES[l] & ~(9'b1 << b)))
                        win_set[b] = 1'b1;
                    if ((opp_i & WIN_LINES[l]) == (WIN_LINES[l] & ~(9'b1 << b)))
                        blk_set[b] = 1'b1;
                end
            end
        end

        valid_o = |free;
        if (|win_set)
            tile_o = lowest_tile(win_set);
        else if (|blk_set)
            tile_o = lowest_tile(blk_set);
        else if (free[tile_to_bit(4'd5)])
            tile_o = 4'd5;
        else
            tile_o = lowest_tile(free);
    end

endmodule

// File: rtl/turn_sequencer.sv
// Button-to-move front end for the tic-tac-toe game state block.
// Define AUTO_O_EN to let an on-chip picker play O after AUTO_DELAY_CYC idle cycles.
module turn_sequencer
    import tictac_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 4,
    parameter int AUTO_DELAY_CYC = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    input  logic [8:0] x_state,
    input  logic [8:0] o_state,
    input  logic [2:0] game_status,
    output logic       move,
    output logic       player,
    output logic [3:0] next_move,
    output logic [3:0] cursor,
    output logic       busy,
    output logic       reject,
    output logic       game_over
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t             state_q,  state_d;
    logic [3:0]         cursor_q, cursor_d;
    logic [3:0]         tgt_q,    tgt_d;
    logic               player_q, player_d;
    logic               reject_q, reject_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [8:0] occ;
    logic [8:0] mover_vec;
    logic       game_end;
    logic       auto_turn;
    logic       auto_go;
    logic [3:0] pick_tile;

    assign occ       = x_state | o_state;
    assign mover_vec = player_q ? x_state : o_state;
    assign game_end  = (game_status == ST_XWIN) || (game_status == ST_OWIN) ||
                       (game_status == ST_DRAW);

`ifdef AUTO_O_EN
    localparam int AW = $clog2(AUTO_DELAY_CYC + 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          pick_vld;

    auto_move_picker u_picker (
        .own_i   (o_state),
        .opp_i   (x_state),
        .tile_o  (pick_tile),
        .valid_o (pick_vld)
    );

    assign auto_turn = (player_q == PLAYER_O);
    assign auto_go   = (state_q == IDLE) && auto_turn && pick_vld &&
                       (auto_cnt_q == AW'(AUTO_DELAY_CYC - 1));

    // Saturates so a full board just parks here until the draw status arrives.
    always_comb begin
        auto_cnt_d = '0;
        if ((state_q == IDLE) && auto_turn && !auto_go) begin
            if (auto_cnt_q == AW'(AUTO_DELAY_CYC - 1))
                auto_cnt_d = auto_cnt_q;
            else
                auto_cnt_d = auto_cnt_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) auto_cnt_q <= '0;
        else        auto_cnt_q <= auto_cnt_d;
    end
`else
    logic unused_auto;

    assign auto_turn   = 1'b0;
    assign auto_go     = 1'b0;
    assign pick_tile   = 4'd0;
    assign unused_auto = (AUTO_DELAY_CYC > 0);
`endif

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        tgt_d    = tgt_q;
        player_d = player_q;
        reject_d = 1'b0;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (auto_turn) begin
                    if (auto_go) begin
                        tgt_d   = pick_tile;
                        state_d = ISSUE;
                    end
                end else if (btn_place) begin
                    if (occ[tile_to_bit(cursor_q)]) begin
                        reject_d = 1'b1;
                    end else begin
                        tgt_d   = cursor_q;
                        state_d = ISSUE;
                    end
                end else if (btn_right && !btn_left) begin
                    cursor_d = (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
                end else if (btn_left && !btn_right) begin
                    cursor_d = (cursor_q == 4'd1) ? 4'd9 : cursor_q - 4'd1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (mover_vec[tile_to_bit(tgt_q)]) begin
                    player_d = ~player_q;
                    state_d  = IDLE;
                end else if ((game_status == ST_BAD) ||
                             (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
                    reject_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: state_d = IDLE;
        endcase

        // A finished game wins over whatever the current state decided.
        if (game_end) begin
            state_d  = OVER;
            reject_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cursor_q <= 4'd5;
            tgt_q    <= 4'd0;
            player_q <= PLAYER_X;
            reject_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            tgt_q    <= tgt_d;
            player_q <= player_d;
            reject_q <= reject_d;
            cnt_q    <= cnt_d;
        end
    end

    assign move      = (state_q == ISSUE);
    assign next_move = move ? tgt_q : 4'd0;
    assign player    = player_q;
    assign cursor    = cursor_q;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);
    assign reject    = reject_q;
    assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a cycle-level reference of the turn rules.
module tb_turn_sequencer;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_place = 1'b0;
    logic [8:0] x_state = '0, o_state = '0;
    logic [2:0] game_status = 3'd0;
    logic       move, player, busy, reject, game_over;
    logic [3:0] next_move, cursor;

    int checks = 0;
    int errors = 0;

`ifdef AUTO_O_EN
    bit model_on = 1'b0;
`else
    bit model_on = 1'b1;
`endif

    always #5 clk = ~clk;

    turn_sequencer #(.TIMEOUT_CYC(TO), .AUTO_DELAY_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_left(btn_left), .btn_right(btn_right), .btn_place(btn_place),
        .x_state(x_state), .o_state(o_state), .game_status(game_status),
        .move(move), .player(player), .next_move(next_move), .cursor(cursor),
        .busy(busy), .reject(reject), .game_over(game_over)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: phase 0 idle, 1 strobe, 2 awaiting board, 3 game over.
    int   m_phase = 0, m_cursor = 5, m_tgt = 0, m_age = 0;
    logic m_turn = 1'b1, m_rej = 1'b0;

    always @(posedge clk) begin
        logic [8:0] occ, mv;
        occ = x_state | o_state;
        mv  = m_turn ? x_state : o_state;
        if (!rst_n) begin
            m_phase = 0; m_cursor = 5; m_tgt = 0; m_turn = 1'b1; m_rej = 1'b0; m_age = 0;
        end else begin
            m_rej = 1'b0;
            if (m_phase == 0) begin
                if (btn_place) begin
                    if (occ[9 - m_cursor]) m_rej = 1'b1;
                    else begin m_tgt = m_cursor; m_phase = 1; end
                end else if (btn_right && !btn_left) m_cursor = (m_cursor % 9) + 1;
                else if (btn_left && !btn_right) m_cursor = ((m_cursor + 7) % 9) + 1;
            end else if (m_phase == 1) begin
                m_phase = 2; m_age = 0;
            end else if (m_phase == 2) begin
                m_age++;
                if (mv[9 - m_tgt]) begin m_turn = ~m_turn; m_phase = 0; end
                else if (game_status == 3'd4 || m_age == TO) begin m_rej = 1'b1; m_phase = 0; end
            end
            if (game_status >= 3'd1 && game_status <= 3'd3) begin
                m_phase = 3; m_rej = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (model_on) begin
            chk("move", int'(move), int'(m_phase == 1));
            chk("next_move", int'(next_move), (m_phase == 1) ? m_tgt : 0);
            chk("player", int'(player), int'(m_turn));
            chk("cursor", int'(cursor), m_cursor);
            chk("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
            chk("reject", int'(reject), int'(m_rej));
            chk("game_over", int'(game_over), int'(m_phase == 3));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic press(input bit l, input bit r, input bit p);
        @(negedge clk); btn_left = l; btn_right = r; btn_place = p;
        @(negedge clk); btn_left = 1'b0; btn_right = 1'b0; btn_place = 1'b0;
    endtask

    task automatic wait_move(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (move) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=no-strobe expected=strobe", name);
        end
    endtask

    initial begin
        int n;
        bit got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cursor", int'(cursor), 5);
        chk("rst_player", int'(player), 1);
        chk("rst_move", int'(move), 0);
        rst_n = 1'b1;

`ifdef AUTO_O_EN
        press(0, 0, 1);
        wait_move("auto_x_strobe");
        @(negedge clk);
        x_state = 9'b000_110_000;
        o_state = 9'b110_000_000;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (move) break;
            if (!busy) n++;
        end
        wait_move("auto_o_strobe");
        chk("auto_next_move", int'(next_move), 3);
        chk("auto_player", int'(player), 0);
        chk("auto_idle_cycles", n, 8);
`else
        press(0, 1, 0); chk("cur_r1", int'(cursor), 6);
        press(0, 1, 0); chk("cur_r2", int'(cursor), 7);
        press(0, 1, 0); chk("cur_r3", int'(cursor), 8);
        press(0, 1, 0); chk("cur_r4", int'(cursor), 9);
        press(0, 1, 0); chk("cur_wrap_r", int'(cursor), 1);
        press(1, 0, 0); chk("cur_wrap_l", int'(cursor), 9);
        repeat (4) press(1, 0, 0);
        chk("cur_back5", int'(cursor), 5);
        press(1, 1, 0); chk("cur_both", int'(cursor), 5);

        // X at 5, place taking priority over right; board echoes a cycle later.
        press(0, 1, 1);
        wait_move("accept_strobe");
        chk("accept_next_move", int'(next_move), 5);
        chk("accept_player", int'(player), 1);
        chk("accept_cursor", int'(cursor), 5);
        @(negedge clk); x_state = 9'b000_010_000;
        @(negedge clk);
        chk("accept_turn", int'(player), 0);
        chk("accept_busy", int'(busy), 0);
        chk("accept_noreject", int'(reject), 0);

        press(0, 0, 1);
        chk("occ_reject", int'(reject), 1);
        chk("occ_nomove", int'(move), 0);
        chk("occ_player", int'(player), 0);
        @(negedge clk);
        chk("occ_reject_pulse", int'(reject), 0);

        // Tile 6 with no board response: times out.
        press(0, 1, 0);
        press(0, 0, 1);
        wait_move("timeout_strobe");
        n = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (reject) begin got = 1'b1; break; end
            if (busy && !move) n++;
        end
        chk("timeout_seen", int'(got), 1);
        chk("timeout_cycles", n, TO);
        chk("timeout_player", int'(player), 0);

        press(0, 0, 1);
        wait_move("reissue_strobe");
        chk("reissue_next_move", int'(next_move), 6);
        chk("reissue_player", int'(player), 0);
        @(negedge clk); o_state = 9'b000_001_000;
        @(negedge clk);
        chk("reissue_turn", int'(player), 1);

        // Invalid-move status while waiting on tile 7.
        press(0, 1, 0);
        press(0, 0, 1);
        wait_move("bad_strobe");
        @(negedge clk); game_status = 3'd4;
        @(negedge clk);
        chk("bad_reject", int'(reject), 1);
        chk("bad_player", int'(player), 1);
        game_status = 3'd0;

        press(0, 0, 1);
        wait_move("win_strobe");
        @(negedge clk); game_status = 3'd1;
        @(negedge clk);
        chk("over_flag", int'(game_over), 1);
        chk("over_busy", int'(busy), 0);
        press(0, 0, 1);
        @(negedge clk);
        chk("over_nomove", int'(move), 0);
        chk("over_sticky", int'(game_over), 1);

        rst_n = 1'b0; game_status = 3'd0;
        @(negedge clk);
        chk("rst2_cursor", int'(cursor), 5);
        chk("rst2_player", int'(player), 1);
        chk("rst2_over", int'(game_over), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_next_move", int'(next_move), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
